// File: rtl/ofdm_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_pkg
// Shared constants and types for the OFDM transmit back end.
//   OFDM_N      : IFFT points per OFDM symbol
//   OFDM_CP     : cyclic-prefix length in samples
//   OFDM_W      : sample width, {re[W/2-1:0], im[W/2-1:0]}
//   OFDM_LOG2N  : index width for OFDM_N points
//   rd_state_e  : read-side FSM encoding of the cyclic-prefix inserter
//   idx_bits()  : index width for an arbitrary point count (at least 1 bit)
// ---------------------------------------------------------------------------
package ofdm_pkg;

   localparam int OFDM_N     = 16;
   localparam int OFDM_CP    = 4;
   localparam int OFDM_W     = 32;
   localparam int OFDM_LOG2N = $clog2(OFDM_N);

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_PREFIX = 2'd1,
      RD_BODY   = 2'd2
   } rd_state_e;

   function automatic int idx_bits(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cp_sym_ram.sv
// ---------------------------------------------------------------------------
// cp_sym_ram
// Two-bank symbol store for the cyclic-prefix inserter. The bank select is
// the address MSB; the lower AW bits are the sample index inside the bank.
// Contents are never reset.
//   aclk    : clock
//   we_i    : write enable
//   waddr_i : write address {bank, index}
//   wdata_i : write data
//   raddr_i : read address {bank, index}
//   rdata_o : asynchronous read data
// ---------------------------------------------------------------------------
module cp_sym_ram
   import ofdm_pkg::*;
#(
   parameter int N  = OFDM_N,
   parameter int W  = OFDM_W,
   parameter int AW = idx_bits(OFDM_N)
) (
   input  logic          aclk,
   input  logic          we_i,
   input  logic [AW:0]   waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW:0]   raddr_i,
   output logic [W-1:0]  rdata_o
);

   // Full power-of-two depth so every {bank, index} address is in range even
   // when N is not a power of two; the unused tail words are never touched.
   localparam int DEPTH = 2 ** (AW + 1);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge aclk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cp_inserter.sv
// ---------------------------------------------------------------------------
// cp_inserter
// Inserts a cyclic prefix in front of each N-sample IFFT output symbol.
// Input symbols are captured into a ping-pong pair of banks; each full bank
// is replayed as x[N-CP..N-1] (prefix, tuser=1) followed by x[0..N-1]
// (body, tlast on the final sample).
//   aclk                : clock, rising edge
//   aresetn             : asynchronous active-low reset
//   s_axis_data_tdata   : input sample
//   s_axis_data_tvalid  : input sample valid
//   s_axis_data_tlast   : input frame end marker (checked, not used to frame)
//   s_axis_data_tready  : write bank is empty and can take a sample
//   m_axis_data_tdata   : output sample (registered)
//   m_axis_data_tvalid  : output valid (registered)
//   m_axis_data_tlast   : last sample of the N+CP symbol (registered)
//   m_axis_data_tuser   : sample belongs to the prefix (registered)
//   m_axis_data_tready  : downstream accepts the output
//   err_tlast           : one-cycle pulse when tlast disagrees with framing
// ---------------------------------------------------------------------------
module cp_inserter
   import ofdm_pkg::*;
#(
   parameter int N  = OFDM_N,
   parameter int CP = OFDM_CP,
   parameter int W  = OFDM_W
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic [W-1:0]  s_axis_data_tdata,
   input  logic          s_axis_data_tvalid,
   input  logic          s_axis_data_tlast,
   output logic          s_axis_data_tready,
   output logic [W-1:0]  m_axis_data_tdata,
   output logic          m_axis_data_tvalid,
   output logic          m_axis_data_tlast,
   output logic          m_axis_data_tuser,
   input  logic          m_axis_data_tready,
   output logic          err_tlast
);

   localparam int            AW       = idx_bits(N);
   localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
   localparam logic [AW-1:0] IDX_CP0  = AW'(N - CP);

   // Bank occupancy: 1 = FULL, 0 = EMPTY
   logic [1:0]    full_q;
   logic [1:0]    full_d;

   logic          wr_bank_q;
   logic [AW-1:0] wr_idx_q;
   logic [AW-1:0] wr_idx_inc;

   rd_state_e     state_q;
   logic          rd_bank_q;
   logic [AW-1:0] rd_idx_q;
   logic [AW-1:0] rd_idx_inc;
   logic [AW:0]   rd_addr_d;
   logic [W-1:0]  rd_data;

   logic [W-1:0]  m_data_q;
   logic          m_valid_q;
   logic          m_last_q;
   logic          m_user_q;
   logic          err_q;

   logic          in_fire;
   logic          out_fire;
   logic          wr_done;
   logic          rd_done;

   assign s_axis_data_tready = ~full_q[wr_bank_q];
   assign in_fire            = s_axis_data_tvalid & s_axis_data_tready;
   assign out_fire           = m_valid_q & m_axis_data_tready;
   assign wr_done            = in_fire & (wr_idx_q == IDX_LAST);
   assign rd_done            = out_fire & (state_q == RD_BODY) & (rd_idx_q == IDX_LAST);

   assign wr_idx_inc = wr_idx_q + 1'b1;
   assign rd_idx_inc = rd_idx_q + 1'b1;

   // The write side only ever targets an EMPTY bank and the read side only a
   // FULL one, so a fill and a drain in the same cycle always hit different
   // banks and both updates land.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign full_d[gi] = (wr_done && (wr_bank_q == 1'(gi))) ? 1'b1 :
                          (rd_done && (rd_bank_q == 1'(gi))) ? 1'b0 :
                          full_q[gi];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         full_q    <= 2'b00;
         wr_bank_q <= 1'b0;
         wr_idx_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         full_q <= full_d;
         // tlast is only checked against the sample count; it never
         // re-aligns wr_idx.
         err_q  <= in_fire & (s_axis_data_tlast ^ (wr_idx_q == IDX_LAST));
         if (in_fire) begin
            if (wr_idx_q == IDX_LAST) begin
               wr_idx_q  <= '0;
               wr_bank_q <= ~wr_bank_q;
            end else begin
               wr_idx_q  <= wr_idx_inc;
            end
         end
      end
   end

   // Address of the sample the output register will load next. Only used on
   // cycles where the FSM below actually loads.
   always_comb begin
      rd_addr_d = {rd_bank_q, IDX_CP0};
      case (state_q)
         RD_PREFIX: rd_addr_d = (rd_idx_q == IDX_LAST) ? {rd_bank_q, {AW{1'b0}}}
                                                       : {rd_bank_q, rd_idx_inc};
         RD_BODY:   rd_addr_d = (rd_idx_q == IDX_LAST) ? {~rd_bank_q, IDX_CP0}
                                                       : {rd_bank_q, rd_idx_inc};
         default:   rd_addr_d = {rd_bank_q, IDX_CP0};
      endcase
   end

   cp_sym_ram #(
      .N  (N),
      .W  (W),
      .AW (AW)
   ) u_ram (
      .aclk    (aclk),
      .we_i    (in_fire),
      .waddr_i ({wr_bank_q, wr_idx_q}),
      .wdata_i (s_axis_data_tdata),
      .raddr_i (rd_addr_d),
      .rdata_o (rd_data)
   );

   // Read FSM. The output register only changes on entry from IDLE or on an
   // accepted transfer, which keeps the beat stable during backpressure.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= RD_IDLE;
         rd_bank_q <= 1'b0;
         rd_idx_q  <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_user_q  <= 1'b0;
      end else begin
         case (state_q)
            RD_IDLE: begin
               if (full_q[rd_bank_q]) begin
                  state_q   <= RD_PREFIX;
                  rd_idx_q  <= IDX_CP0;
                  m_data_q  <= rd_data;
                  m_valid_q <= 1'b1;
                  m_user_q  <= 1'b1;
                  m_last_q  <= 1'b0;
               end
            end
            RD_PREFIX: begin
               if (out_fire) begin
                  m_data_q <= rd_data;
                  if (rd_idx_q == IDX_LAST) begin
                     state_q  <= RD_BODY;
                     rd_idx_q <= '0;
                     m_user_q <= 1'b0;
                     m_last_q <= 1'b0;
                  end else begin
                     rd_idx_q <= rd_idx_inc;
                  end
               end
            end
            RD_BODY: begin
               if (out_fire) begin
                  if (rd_idx_q == IDX_LAST) begin
                     rd_bank_q <= ~rd_bank_q;
                     m_last_q  <= 1'b0;
                     // Chain straight into the other bank when it is ready
                     // so consecutive symbols stream without a gap.
                     if (full_q[~rd_bank_q]) begin
                        state_q   <= RD_PREFIX;
                        rd_idx_q  <= IDX_CP0;
                        m_data_q  <= rd_data;
                        m_valid_q <= 1'b1;
                        m_user_q  <= 1'b1;
                     end else begin
                        state_q   <= RD_IDLE;
                        rd_idx_q  <= '0;
                        m_valid_q <= 1'b0;
                        m_user_q  <= 1'b0;
                     end
                  end else begin
                     rd_idx_q <= rd_idx_inc;
                     m_data_q <= rd_data;
                     m_last_q <= (rd_idx_inc == IDX_LAST);
                  end
               end
            end
            default: begin
               state_q   <= RD_IDLE;
               m_valid_q <= 1'b0;
               m_last_q  <= 1'b0;
               m_user_q  <= 1'b0;
            end
         endcase
      end
   end

   assign m_axis_data_tdata  = m_data_q;
   assign m_axis_data_tvalid = m_valid_q;
   assign m_axis_data_tlast  = m_last_q;
   assign m_axis_data_tuser  = m_user_q;
   assign err_tlast          = err_q;

endmodule

// File: tb/tb_cp_inserter.sv
// ---------------------------------------------------------------------------
// tb_cp_inserter
// Directed bench for cp_inserter: a table of symbol-stream scenarios run
// through one driver/checker loop, plus hand-written reset sequences.
// ---------------------------------------------------------------------------
module tb_cp_inserter;

   localparam int N  = 16;
   localparam int CP = 4;
   localparam int W  = 32;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b1;
   logic [W-1:0]  s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic [W-1:0]  m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_user;
   logic          m_ready = 1'b0;
   logic          err;

   cp_inserter #(
      .N  (N),
      .CP (CP),
      .W  (W)
   ) dut (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .s_axis_data_tdata  (s_data),
      .s_axis_data_tvalid (s_valid),
      .s_axis_data_tlast  (s_last),
      .s_axis_data_tready (s_ready),
      .m_axis_data_tdata  (m_data),
      .m_axis_data_tvalid (m_valid),
      .m_axis_data_tlast  (m_last),
      .m_axis_data_tuser  (m_user),
      .m_axis_data_tready (m_ready),
      .err_tlast          (err)
   );

   always #5 aclk = ~aclk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } in_t;

   typedef struct {
      logic [W-1:0] data;
      logic         user;
      logic         last;
   } out_t;

   typedef struct {
      int frames;
      bit rnd;
      int extra_tlast;   // input index with a spurious tlast, -1 for none
      bit drop_last;     // omit tlast on sample N-1
      int exp_outs;
      int exp_errs;
      int exp_stalls;
      int exp_span;      // -1: not checked (random backpressure)
   } case_t;

   in_t  in_q[$];
   out_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Reference symbol stream: each N-sample frame becomes its last CP samples
   // (tuser=1) followed by all N samples, tlast on the final one.
   task automatic build(input int frames, input int extra_tlast, input bit drop_last,
                        input int base);
      in_t  ti;
      out_t to;
      in_q.delete();
      exp_q.delete();
      for (int f = 0; f < frames; f++) begin
         for (int k = 0; k < N; k++) begin
            ti.data = W'(base + f * 256 + k);
            ti.last = ((k == N - 1) && !drop_last) || (k == extra_tlast);
            in_q.push_back(ti);
         end
         for (int j = N - CP; j < N; j++) begin
            to.data = W'(base + f * 256 + j);
            to.user = 1'b1;
            to.last = 1'b0;
            exp_q.push_back(to);
         end
         for (int j = 0; j < N; j++) begin
            to.data = W'(base + f * 256 + j);
            to.user = 1'b0;
            to.last = (j == N - 1);
            exp_q.push_back(to);
         end
      end
   endtask

   task automatic run(input string tag, input bit rnd, input int stop_ins, input int stop_outs,
                      output int n_out, output int n_err, output int n_stall,
                      output int span, output int lat);
      int in_ptr = 0;
      int out_ptr = 0;
      int cyc = 0;
      int idle = 0;
      int first_out = -1;
      int last_out = -1;
      int last_in = -1;
      int first_valid = -1;
      bit prev_stall = 1'b0;
      logic [W+1:0] prev = '0;
      n_err = 0;
      n_stall = 0;
      forever begin
         @(negedge aclk);
         s_valid = (in_ptr < in_q.size());
         if (s_valid) begin
            s_data = in_q[in_ptr].data;
            s_last = in_q[in_ptr].last;
         end else begin
            s_data = '0;
            s_last = 1'b0;
         end
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (prev_stall) begin
            chk({tag, "_hold"}, {m_valid, m_user, m_last, m_data}, {1'b1, prev});
         end
         if (err) n_err++;
         if (m_valid && first_valid < 0) first_valid = cyc;
         if (s_valid && !s_ready) n_stall++;
         if (s_valid && s_ready) begin
            if (in_ptr == N - 1) last_in = cyc;
            in_ptr++;
         end
         if (m_valid && m_ready) begin
            if (out_ptr < exp_q.size()) begin
               $display("%s beat %0d: data=%08h user=%b last=%b", tag, out_ptr, m_data, m_user, m_last);
               chk({tag, "_data"}, m_data, exp_q[out_ptr].data);
               chk({tag, "_user"}, m_user, exp_q[out_ptr].user);
               chk({tag, "_last"}, m_last, exp_q[out_ptr].last);
            end else begin
               chk({tag, "_extra_beat"}, out_ptr, exp_q.size());
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            out_ptr++;
         end
         prev_stall = m_valid && !m_ready;
         prev = {m_user, m_last, m_data};
         cyc++;
         if (stop_ins > 0 && in_ptr == stop_ins) break;
         if (stop_outs > 0 && out_ptr == stop_outs) break;
         if (in_ptr == in_q.size() && out_ptr >= exp_q.size()) begin
            idle++;
            if (idle > 4) break;
         end
         if (cyc > 3000) begin
            chk({tag, "_timeout"}, cyc, 3000);
            break;
         end
      end
      n_out = out_ptr;
      span  = last_out - first_out + 1;
      lat   = first_valid - last_in;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, m_valid, 1'b0);
      chk({tag, "_tlast"}, m_last, 1'b0);
      chk({tag, "_tuser"}, m_user, 1'b0);
      chk({tag, "_tdata"}, m_data, '0);
      chk({tag, "_err"}, err, 1'b0);
      chk({tag, "_sready"}, s_ready, 1'b1);
   endtask

   case_t cases[5];

   initial begin
      int n_out, n_err, n_stall, span, lat;
      string tag;

      cases[0] = '{frames: 1, rnd: 0, extra_tlast: -1, drop_last: 0,
                   exp_outs: 20, exp_errs: 0, exp_stalls: 0, exp_span: 20};
      cases[1] = '{frames: 3, rnd: 0, extra_tlast: -1, drop_last: 0,
                   exp_outs: 60, exp_errs: 0, exp_stalls: 5, exp_span: 60};
      cases[2] = '{frames: 1, rnd: 1, extra_tlast: -1, drop_last: 0,
                   exp_outs: 20, exp_errs: 0, exp_stalls: 0, exp_span: -1};
      cases[3] = '{frames: 1, rnd: 0, extra_tlast: 9, drop_last: 0,
                   exp_outs: 20, exp_errs: 1, exp_stalls: 0, exp_span: 20};
      cases[4] = '{frames: 1, rnd: 0, extra_tlast: -1, drop_last: 1,
                   exp_outs: 20, exp_errs: 1, exp_stalls: 0, exp_span: 20};

      // Power-on reset: outputs must clear without waiting for a clock edge.
      #1;
      aresetn = 1'b0;
      #1;
      check_reset_outputs("por");
      @(negedge aclk);
      aresetn = 1'b1;

      for (int i = 0; i < 5; i++) begin
         tag = $sformatf("case%0d", i);
         build(cases[i].frames, cases[i].extra_tlast, cases[i].drop_last, 0);
         run(tag, cases[i].rnd, 0, 0, n_out, n_err, n_stall, span, lat);
         chk({tag, "_outs"}, n_out, cases[i].exp_outs);
         chk({tag, "_errs"}, n_err, cases[i].exp_errs);
         chk({tag, "_stalls"}, n_stall, cases[i].exp_stalls);
         chk({tag, "_latency"}, lat, 2);
         if (cases[i].exp_span >= 0) begin
            chk({tag, "_span"}, span, cases[i].exp_span);
         end
      end

      // Reset in the middle of an input frame: the 7 captured samples must be
      // dropped and the next frame framed from sample 0.
      build(1, -1, 0, 'h1000);
      run("rstin_pre", 1'b0, 7, 0, n_out, n_err, n_stall, span, lat);
      @(posedge aclk);
      #2;
      s_valid = 1'b0;
      aresetn = 1'b0;
      #1;
      check_reset_outputs("rstin");
      @(negedge aclk);
      aresetn = 1'b1;
      build(1, -1, 0, 0);
      run("rstin_post", 1'b0, 0, 0, n_out, n_err, n_stall, span, lat);
      chk("rstin_post_outs", n_out, 20);
      chk("rstin_post_errs", n_err, 0);

      // Reset while a symbol is being output (after 10 accepted beats):
      // tvalid must drop at once, not at the next edge.
      build(1, -1, 0, 'h2000);
      run("rstout_pre", 1'b0, 0, 10, n_out, n_err, n_stall, span, lat);
      @(posedge aclk);
      #2;
      s_valid = 1'b0;
      chk("rstout_pre_valid", m_valid, 1'b1);
      aresetn = 1'b0;
      #1;
      check_reset_outputs("rstout");
      @(negedge aclk);
      aresetn = 1'b1;
      build(1, -1, 0, 'h3000);
      run("rstout_post", 1'b0, 0, 0, n_out, n_err, n_stall, span, lat);
      chk("rstout_post_outs", n_out, 20);
      chk("rstout_post_errs", n_err, 0);
      chk("rstout_post_latency", lat, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
